xadac_vec_issue: RTL and testbench
==================================

Name: xadac_vec_issue

Overview:
- Issue/writeback stage directly upstream of the xadac execute units (vmacc and siblings).
- Accepts decoded vector instructions and reads vs1/vs2/vs3 from an internal vector register file (VRF).
- Blocks on register hazards with a per-register scoreboard, then drives the execute request channel.
- Consumes the execute response channel and writes resp_vd back into the VRF.

Parameters:
- NrVRegs, 32, number of vector registers.
- VecWidth, xadac_pkg::VectorWidth (128), bits per vector register.
- IdWidth, 3, width of the instruction tag; at most 2**IdWidth instructions in flight.
- ImmWidth, 5, width of the immediate forwarded to execute.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- dec_valid_i  in  1  decoded instruction valid.
- dec_ready_o  out  1  decoded instruction accepted this cycle.
- dec_id_i  in  IdWidth  instruction tag.
- dec_vd_i / dec_vs1_i / dec_vs2_i / dec_vs3_i  in  $clog2(NrVRegs) each  register addresses.
- dec_we_i  in  1  instruction writes vd.
- dec_imm_i  in  ImmWidth  immediate.
- ex_req_valid_o  out  1  execute request valid.
- ex_req_ready_i  in  1  execute unit ready.
- ex_req_id_o  out  IdWidth  tag.
- ex_req_imm_o  out  ImmWidth  immediate.
- ex_req_vs1_o / ex_req_vs2_o / ex_req_vs3_o  out  VecWidth each  operands.
- ex_resp_valid_i  in  1  response valid.
- ex_resp_ready_o  out  1  tied to 1.
- ex_resp_id_i  in  IdWidth  response tag.
- ex_resp_vd_i  in  VecWidth  result.
- inflight_o  out  IdWidth+1  number of outstanding instructions.
- err_o  out  1  one-cycle pulse on a response whose tag is not in flight.

Behaviour:
- Reset (rst_i sampled high at clk_i edge):
  - ex_req_valid_o=0, inflight_o=0, err_o=0.
  - All scoreboard bits cleared, all tag-table valid bits cleared, all VRF entries set to 0.
  - Every other registered output is set to 0.
- Tag table: one entry per tag, holding {valid, vd, we}.
  - Written on dec accept.
  - Cleared on response accept.
- Scoreboard: one pending bit per vreg.
  - Set for vd on accept when dec_we_i=1.
  - Cleared when the matching response writes back.
- Hazard: a dec_valid_i instruction stalls while any of the following holds:
  - Any of vs1, vs2, vs3 (RAW) is pending.
  - vd (WAW) is pending and dec_we_i=1.
  - The tag table entry for dec_id_i is valid.
  - inflight_o == 2**IdWidth.
- Accept: dec_ready_o = !hazard && (!ex_req_valid_o || ex_req_ready_i).
  - dec_ready_o never depends on dec_valid_i.
- On accept, the ex_req_* registers load id, imm and the three VRF reads.
  - ex_req_valid_o rises the next cycle, so latency is 1 cycle from dec accept to request.
- Request channel: ex_req_* is held stable while ex_req_valid_o=1 and ex_req_ready_i=0.
  - ex_req_valid_o drops after the handshake unless a new accept occurs in the same cycle (back-to-back, full throughput).
- Response (ex_resp_valid_i=1, always accepted), when the tag entry is valid:
  - If we=1, write ex_resp_vd_i to VRF[vd] and clear pending[vd].
  - Invalidate the tag entry and decrement the in-flight count.
- Response with an invalid tag: no state change; err_o=1 for one cycle.
- Same-cycle response and dec accept:
  - The scoreboard clear and tag free are visible to the hazard check in that cycle.
  - VRF reads of the register being written return ex_resp_vd_i (write-through bypass).
  - The in-flight count is unchanged (+1, -1).
- Same-cycle clear and set of the same vd: set wins, so the register stays pending.
- Reset mid-operation: outstanding work is discarded.
  - Responses arriving after reset pulse err_o and do not touch the VRF.
- Arithmetic: the in-flight count is IdWidth+1 bits and cannot exceed 2**IdWidth or underflow, by construction.

Decomposition:
- xadac_pkg holds:
  - VectorWidth.
  - Types vreg_addr_t, xadac_id_t, vreg_t.
  - Struct issue_entry_t {valid, vd, we}.
- Sub-module xadac_vrf:
  - NrVRegs x VecWidth registers.
  - 3 combinational read ports, 1 write port.
  - Write-through bypass; synchronous reset to zero.
- The scoreboard, tag table and request register stay in xadac_vec_issue.

Test Plan:
- Basic flow: after reset, issue id=0 (vs1=1, vs2=2, vs3=3, vd=4, we=1) with ex_req_ready_i=1.
  - Next cycle: ex_req_valid_o=1 with all operands 0.
  - Respond id=0, vd=0xA5.
  - Next cycle: VRF[4]=0xA5, inflight_o=0.
- RAW stall: issue vd=5; then issue vs1=5.
  - dec_ready_o=0 until the response for vd=5 arrives.
  - In the response cycle dec_ready_o=1 and ex_req_vs1_o next cycle equals the response data (bypass).
- Backpressure: hold ex_req_ready_i=0 for 3 cycles.
  - ex_req_* stays stable and dec_ready_o=0.
  - Release: one handshake, and a pending dec is accepted in the same cycle.
- Capacity: IdWidth=3, issue 8 independent instructions with no responses.
  - inflight_o=8, 9th dec_ready_o=0.
  - One response leads to an accept in the same cycle, with inflight_o staying 8.
- Error/reset: a response with id=6 when not in flight gives err_o=1 for exactly 1 cycle and the VRF unchanged.
  - Assert rst_i with 2 in flight: inflight_o=0, VRF all zero.
  - Late responses pulse err_o.

Source files
------------

// File: rtl/xadac_pkg.sv
// Shared widths and types for the xadac vector issue stage.
// Register addresses, instruction tags, vector data and the tag-table entry.
package xadac_pkg;

  localparam int unsigned VectorWidth = 128;
  localparam int unsigned NrVRegsDef  = 32;
  localparam int unsigned IdWidthDef  = 3;

  typedef logic [$clog2(NrVRegsDef)-1:0] vreg_addr_t;
  typedef logic [IdWidthDef-1:0]         xadac_id_t;
  typedef logic [VectorWidth-1:0]        vreg_t;

  typedef struct packed {
    logic       valid;
    vreg_addr_t vd;
    logic       we;
  } issue_entry_t;

endpackage

// File: rtl/xadac_vrf.sv
// Vector register file: 3 combinational read ports and 1 write port.
// Reads return same-cycle write data (write-through); no backpressure.
module xadac_vrf #(
  parameter int unsigned NrVRegs   = 32,
  parameter int unsigned VecWidth  = 128,
  parameter int unsigned AddrWidth = $clog2(NrVRegs)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] rd_addr_i [3],
  output logic [VecWidth-1:0]  rd_data_o [3],
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [VecWidth-1:0]  wr_data_i
);

  logic [VecWidth-1:0] mem_q [NrVRegs];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrVRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Bypass lets an instruction issue in the same cycle its source is written back.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rd_data_o[r] = mem_q[rd_addr_i[r]];
      if (wr_en_i && (wr_addr_i == rd_addr_i[r])) begin
        rd_data_o[r] = wr_data_i;
      end
    end
  end

endmodule

// File: rtl/xadac_vec_issue.sv
// Vector issue/writeback stage: scoreboard hazard check, VRF operand read, request register.
// Dec accept to ex_req_valid is 1 cycle; request held while ex_req_ready_i=0, responses always accepted.
module xadac_vec_issue
  import xadac_pkg::*;
#(
  parameter int unsigned NrVRegs  = 32,
  parameter int unsigned VecWidth = xadac_pkg::VectorWidth,
  parameter int unsigned IdWidth  = 3,
  parameter int unsigned ImmWidth = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dec_valid_i,
  output logic                       dec_ready_o,
  input  logic [IdWidth-1:0]         dec_id_i,
  input  logic [$clog2(NrVRegs)-1:0] dec_vd_i,
  input  logic [$clog2(NrVRegs)-1:0] dec_vs1_i,
  input  logic [$clog2(NrVRegs)-1:0] dec_vs2_i,
  input  logic [$clog2(NrVRegs)-1:0] dec_vs3_i,
  input  logic                       dec_we_i,
  input  logic [ImmWidth-1:0]        dec_imm_i,
  output logic                       ex_req_valid_o,
  input  logic                       ex_req_ready_i,
  output logic [IdWidth-1:0]         ex_req_id_o,
  output logic [ImmWidth-1:0]        ex_req_imm_o,
  output logic [VecWidth-1:0]        ex_req_vs1_o,
  output logic [VecWidth-1:0]        ex_req_vs2_o,
  output logic [VecWidth-1:0]        ex_req_vs3_o,
  input  logic                       ex_resp_valid_i,
  output logic                       ex_resp_ready_o,
  input  logic [IdWidth-1:0]         ex_resp_id_i,
  input  logic [VecWidth-1:0]        ex_resp_vd_i,
  output logic [IdWidth:0]           inflight_o,
  output logic                       err_o
);

  localparam int unsigned AW     = $clog2(NrVRegs);
  localparam int unsigned NrIds  = 1 << IdWidth;
  localparam int unsigned CW     = IdWidth + 1;

  logic [NrVRegs-1:0] pending_q;
  issue_entry_t       tag_q [NrIds];
  logic [CW-1:0]      inflight_q;
  logic               err_q;

  logic               resp_hit;
  issue_entry_t       resp_ent;
  logic               wb_en;
  logic [NrVRegs-1:0] clr_mask;
  logic [NrVRegs-1:0] set_mask;
  logic [NrVRegs-1:0] pending_eff;
  logic [CW-1:0]      inflight_eff;
  logic               tag_busy;
  logic               hazard;
  logic               accept;

  logic [AW-1:0]       rd_addr [3];
  logic [VecWidth-1:0] rd_data [3];

  assign ex_resp_ready_o = 1'b1;
  assign inflight_o      = inflight_q;
  assign err_o           = err_q;

  assign resp_ent = tag_q[ex_resp_id_i];
  assign resp_hit = ex_resp_valid_i && resp_ent.valid;
  assign wb_en    = resp_hit && resp_ent.we;

  // The retiring response is folded in before the hazard check so a freed
  // register, tag or slot can be reused in the very same cycle.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_en) begin
      clr_mask[resp_ent.vd] = 1'b1;
    end
    if (accept && dec_we_i) begin
      set_mask[dec_vd_i] = 1'b1;
    end
  end

  assign pending_eff  = pending_q & ~clr_mask;
  assign inflight_eff = inflight_q - CW'(resp_hit);
  assign tag_busy     = tag_q[dec_id_i].valid && !(resp_hit && (ex_resp_id_i == dec_id_i));

  assign hazard = pending_eff[dec_vs1_i]
               || pending_eff[dec_vs2_i]
               || pending_eff[dec_vs3_i]
               || (dec_we_i && pending_eff[dec_vd_i])
               || tag_busy
               || (inflight_eff == CW'(NrIds));

  assign dec_ready_o = !hazard && (!ex_req_valid_o || ex_req_ready_i);
  assign accept      = dec_valid_i && dec_ready_o;

  assign rd_addr[0] = dec_vs1_i;
  assign rd_addr[1] = dec_vs2_i;
  assign rd_addr[2] = dec_vs3_i;

  xadac_vrf #(
    .NrVRegs  (NrVRegs),
    .VecWidth (VecWidth)
  ) i_vrf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .wr_en_i   (wb_en),
    .wr_addr_i (resp_ent.vd),
    .wr_data_i (ex_resp_vd_i)
  );

  // Set is OR-ed after the clear so a same-cycle clear+set of one vd stays pending.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NrIds; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_eff | set_mask;
      inflight_q <= inflight_q + CW'(accept) - CW'(resp_hit);
      err_q      <= ex_resp_valid_i && !resp_ent.valid;
      if (resp_hit) begin
        tag_q[ex_resp_id_i].valid <= 1'b0;
      end
      if (accept) begin
        tag_q[dec_id_i] <= '{valid: 1'b1, vd: dec_vd_i, we: dec_we_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_req_valid_o <= 1'b0;
      ex_req_id_o    <= '0;
      ex_req_imm_o   <= '0;
      ex_req_vs1_o   <= '0;
      ex_req_vs2_o   <= '0;
      ex_req_vs3_o   <= '0;
    end else if (accept) begin
      ex_req_valid_o <= 1'b1;
      ex_req_id_o    <= dec_id_i;
      ex_req_imm_o   <= dec_imm_i;
      ex_req_vs1_o   <= rd_data[0];
      ex_req_vs2_o   <= rd_data[1];
      ex_req_vs3_o   <= rd_data[2];
    end else if (ex_req_ready_i) begin
      ex_req_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (inflight_q <= CW'(NrIds));
    end
  end

endmodule

// File: tb/tb_xadac_vec_issue.sv
// Scoreboard bench for xadac_vec_issue: expected requests queued on accept, popped by a monitor.
module tb_xadac_vec_issue;

  logic         clk = 1'b0;
  logic         rst;
  logic         dec_valid, dec_ready_o, dec_we;
  logic [2:0]   dec_id;
  logic [4:0]   dec_vd, dec_vs1, dec_vs2, dec_vs3, dec_imm;
  logic         ex_req_valid_o, ex_req_ready;
  logic [2:0]   ex_req_id_o;
  logic [4:0]   ex_req_imm_o;
  logic [127:0] ex_req_vs1_o, ex_req_vs2_o, ex_req_vs3_o;
  logic         resp_valid, ex_resp_ready_o;
  logic [2:0]   resp_id;
  logic [127:0] resp_vd;
  logic [3:0]   inflight_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   id;
    logic [4:0]   imm;
    logic [127:0] v1, v2, v3;
  } req_t;
  req_t exp_q[$];
  req_t mon_e;

  localparam logic [127:0] D1 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

  always #5 clk = ~clk;

  xadac_vec_issue dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .dec_valid_i     (dec_valid),
    .dec_ready_o     (dec_ready_o),
    .dec_id_i        (dec_id),
    .dec_vd_i        (dec_vd),
    .dec_vs1_i       (dec_vs1),
    .dec_vs2_i       (dec_vs2),
    .dec_vs3_i       (dec_vs3),
    .dec_we_i        (dec_we),
    .dec_imm_i       (dec_imm),
    .ex_req_valid_o  (ex_req_valid_o),
    .ex_req_ready_i  (ex_req_ready),
    .ex_req_id_o     (ex_req_id_o),
    .ex_req_imm_o    (ex_req_imm_o),
    .ex_req_vs1_o    (ex_req_vs1_o),
    .ex_req_vs2_o    (ex_req_vs2_o),
    .ex_req_vs3_o    (ex_req_vs3_o),
    .ex_resp_valid_i (resp_valid),
    .ex_resp_ready_o (ex_resp_ready_o),
    .ex_resp_id_i    (resp_id),
    .ex_resp_vd_i    (resp_vd),
    .inflight_o      (inflight_o),
    .err_o           (err_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] id, input logic [4:0] vd, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] s3, input logic we,
                       input logic [4:0] imm, input logic [127:0] e1, input logic [127:0] e2,
                       input logic [127:0] e3);
    int n = 0;
    dec_id = id; dec_vd = vd; dec_vs1 = s1; dec_vs2 = s2; dec_vs3 = s3;
    dec_we = we; dec_imm = imm; dec_valid = 1'b1;
    #2;
    while (!dec_ready_o && n < 20) begin
      step();
      #2;
      n++;
    end
    if (!dec_ready_o) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: id %0d never accepted, expected accept within 20 cycles", id);
      step();
      dec_valid = 1'b0;
      return;
    end
    exp_q.push_back('{id, imm, e1, e2, e3});
    step();
    dec_valid = 1'b0;
  endtask

  task automatic resp(input logic [2:0] id, input logic [127:0] data);
    resp_valid = 1'b1; resp_id = id; resp_vd = data;
    step();
    resp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ex_req_valid_o && ex_req_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got id %0d expected no request", ex_req_id_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("req_id",  ex_req_id_o,  mon_e.id);
        chk("req_imm", ex_req_imm_o, mon_e.imm);
        chk("req_vs1", ex_req_vs1_o, mon_e.v1);
        chk("req_vs2", ex_req_vs2_o, mon_e.v2);
        chk("req_vs3", ex_req_vs3_o, mon_e.v3);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dec_valid = 1'b0; dec_id = '0; dec_vd = '0; dec_vs1 = '0; dec_vs2 = '0;
    dec_vs3 = '0; dec_we = 1'b0; dec_imm = '0; ex_req_ready = 1'b1;
    resp_valid = 1'b0; resp_id = '0; resp_vd = '0;
    step(); step();
    #2;
    chk("rst_req_vld", ex_req_valid_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_err", err_o, 0);
    chk("resp_ready", ex_resp_ready_o, 1);
    step();
    rst = 1'b0;
    #2 chk("idle_dec_ready", dec_ready_o, 1);
    step();

    // Basic flow
    dec_id = 0; dec_vs1 = 1; dec_vs2 = 2; dec_vs3 = 3; dec_vd = 4; dec_we = 1; dec_imm = 7;
    dec_valid = 1'b1;
    #2 chk("basic_dec_ready", dec_ready_o, 1);
    exp_q.push_back('{3'd0, 5'd7, 128'd0, 128'd0, 128'd0});
    step();
    dec_valid = 1'b0;
    #2;
    chk("basic_req_vld", ex_req_valid_o, 1);
    chk("basic_inflight1", inflight_o, 1);
    step();
    resp(0, 128'hA5);
    #2 chk("basic_inflight0", inflight_o, 0);
    issue(1, 0, 4, 0, 0, 0, 1, 128'hA5, 0, 0);
    resp(1, 128'h0);

    // RAW stall with writeback bypass
    issue(2, 5, 0, 0, 0, 1, 2, 0, 0, 0);
    dec_id = 3; dec_vd = 6; dec_vs1 = 5; dec_vs2 = 4; dec_vs3 = 0; dec_we = 1; dec_imm = 3;
    dec_valid = 1'b1;
    #2 chk("raw_stall0", dec_ready_o, 0);
    step();
    #2 chk("raw_stall1", dec_ready_o, 0);
    step();
    resp_valid = 1'b1; resp_id = 2; resp_vd = D1;
    #2 chk("raw_release", dec_ready_o, 1);
    exp_q.push_back('{3'd3, 5'd3, D1, 128'hA5, 128'd0});
    step();
    resp_valid = 1'b0; dec_valid = 1'b0;
    #2 chk("raw_req_vld", ex_req_valid_o, 1);
    step();

    // Backpressure
    resp(3, 128'h66);
    ex_req_ready = 1'b0;
    issue(4, 7, 6, 5, 4, 1, 4, 128'h66, D1, 128'hA5);
    dec_id = 5; dec_vd = 8; dec_vs1 = 1; dec_vs2 = 2; dec_vs3 = 3; dec_we = 1; dec_imm = 5;
    dec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_dec_ready", dec_ready_o, 0);
      chk("bp_req_vld", ex_req_valid_o, 1);
      chk("bp_req_id", ex_req_id_o, 4);
      chk("bp_req_vs1", ex_req_vs1_o, 128'h66);
      step();
    end
    ex_req_ready = 1'b1;
    #2 chk("bp_release", dec_ready_o, 1);
    exp_q.push_back('{3'd5, 5'd5, 128'd0, 128'd0, 128'd0});
    step();
    dec_valid = 1'b0;
    #2;
    chk("bp_next_vld", ex_req_valid_o, 1);
    chk("bp_next_id", ex_req_id_o, 5);
    step();
    resp(4, 128'h77);
    resp(5, 128'h88);
    #2 chk("bp_inflight0", inflight_o, 0);

    // Capacity
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 5'(10 + i), 0, 0, 0, 1, 5'(i), 0, 0, 0);
    end
    #2 chk("cap_inflight8", inflight_o, 8);
    dec_id = 0; dec_vd = 20; dec_vs1 = 10; dec_vs2 = 0; dec_vs3 = 0; dec_we = 1; dec_imm = 9;
    dec_valid = 1'b1;
    step();
    #2 chk("cap_full0", dec_ready_o, 0);
    step();
    #2 chk("cap_full1", dec_ready_o, 0);
    step();
    resp_valid = 1'b1; resp_id = 0; resp_vd = 128'hABCD;
    #2 chk("cap_release", dec_ready_o, 1);
    exp_q.push_back('{3'd0, 5'd9, 128'hABCD, 128'd0, 128'd0});
    step();
    resp_valid = 1'b0; dec_valid = 1'b0;
    #2 chk("cap_inflight_hold", inflight_o, 8);
    step();
    for (int i = 1; i < 8; i++) begin
      resp(3'(i), 128'(i));
    end
    resp(0, 128'h20);
    #2 chk("cap_inflight0", inflight_o, 0);

    // Unknown-tag response
    resp_valid = 1'b1; resp_id = 6; resp_vd = 128'hDEAD;
    #2 chk("err_pre", err_o, 0);
    step();
    resp_valid = 1'b0;
    #2 chk("err_pulse", err_o, 1);
    step();
    #2 chk("err_clear", err_o, 0);
    issue(1, 0, 16, 20, 12, 0, 1, 128'h6, 128'h20, 128'h2);
    resp(1, 128'h1);

    // Reset with work outstanding
    issue(2, 21, 4, 0, 0, 1, 2, 128'hA5, 0, 0);
    issue(3, 22, 0, 0, 0, 1, 3, 0, 0, 0);
    #2 chk("pre_rst_inflight", inflight_o, 2);
    step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #2;
    chk("mid_rst_inflight", inflight_o, 0);
    chk("mid_rst_req_vld", ex_req_valid_o, 0);
    chk("mid_rst_err", err_o, 0);
    step();
    issue(4, 0, 4, 6, 16, 0, 4, 0, 0, 0);
    resp(4, 128'h5);
    resp_valid = 1'b1; resp_id = 2; resp_vd = 128'h99;
    step();
    resp_valid = 1'b0;
    #2 chk("late_err_pulse", err_o, 1);
    step();
    #2 chk("late_err_clear", err_o, 0);
    issue(5, 0, 21, 22, 0, 0, 5, 0, 0, 0);
    resp(5, 128'h5);

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
